// File: rtl/elevator_scheduler_if.sv
// Call/status bundle for the four-floor elevator scheduler.
// The requester drives the call strobe; the scheduler drives the car status.
interface elevator_scheduler_if;
  logic       req_valid;
  logic [1:0] req_floor;
  logic [1:0] req_dir;
  logic [1:0] floor;
  logic [1:0] motion;
  logic       door_open;
  logic [3:0] pending_up;
  logic [3:0] pending_dn;
  logic       busy;

  modport master (
    output req_valid, req_floor, req_dir,
    input  floor, motion, door_open, pending_up, pending_dn, busy
  );

  modport slave (
    input  req_valid, req_floor, req_dir,
    output floor, motion, door_open, pending_up, pending_dn, busy
  );
endinterface

// File: rtl/elevator_scheduler.sv
// Four-floor single-car scheduler: latches hall calls, sweeps in the last
// direction of travel, and holds the door for a programmable time at each stop.
module elevator_scheduler #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  elevator_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

  localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic       last_dir_q, last_dir_d;
  logic [3:0] pend_up_q, pend_up_d;
  logic [3:0] pend_dn_q, pend_dn_d;
  logic [7:0] travel_q, travel_d;
  logic [7:0] door_q, door_d;

  logic       call_ok, call_up, call_dn, call_here;
  logic [3:0] pend_all, calls_above, calls_below;
  logic [1:0] nxt_up, nxt_dn;
  logic       above_nxt_up, below_nxt_dn;
  logic [3:0] set_up, set_dn, clr;

  always_comb begin
    call_up   = bus.req_valid && (bus.req_dir == 2'b11) && (bus.req_floor != 2'd3);
    call_dn   = bus.req_valid && (bus.req_dir == 2'b10) && (bus.req_floor != 2'd0);
    call_ok   = call_up || call_dn;
    call_here = call_ok && (bus.req_floor == floor_q);

    pend_all    = pend_up_q | pend_dn_q;
    calls_above = pend_all & (4'b1110 << floor_q);
    calls_below = pend_all & ~(4'b1111 << floor_q);

    // Direction decisions on arrival look at the floor being reached, not the one left.
    nxt_up       = floor_q + 2'd1;
    nxt_dn       = floor_q - 2'd1;
    above_nxt_up = |(pend_all & (4'b1110 << nxt_up));
    below_nxt_dn = |(pend_all & ~(4'b1111 << nxt_dn));
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    last_dir_d = last_dir_q;
    travel_d   = travel_q;
    door_d     = door_q;

    unique case (state_q)
      IDLE: begin
        if (pend_all[floor_q] || call_here)
          state_d = DOOR;
        else if ((|calls_above) && (|calls_below))
          state_d = last_dir_q ? UP : DOWN;
        else if (|calls_above)
          state_d = UP;
        else if (|calls_below)
          state_d = DOWN;
      end

      UP: begin
        if (floor_q == 2'd3) begin
          state_d  = pend_all[3] ? DOOR : IDLE;
          travel_d = '0;
        end else if (travel_q == TRAVEL_LAST) begin
          floor_d  = nxt_up;
          travel_d = '0;
          if (pend_up_q[nxt_up] || (!above_nxt_up && pend_all[nxt_up]))
            state_d = DOOR;
          else if (!above_nxt_up)
            state_d = IDLE;
        end else begin
          travel_d = travel_q + 8'd1;
        end
      end

      DOWN: begin
        if (floor_q == 2'd0) begin
          state_d  = pend_all[0] ? DOOR : IDLE;
          travel_d = '0;
        end else if (travel_q == TRAVEL_LAST) begin
          floor_d  = nxt_dn;
          travel_d = '0;
          if (pend_dn_q[nxt_dn] || (!below_nxt_dn && pend_all[nxt_dn]))
            state_d = DOOR;
          else if (!below_nxt_dn)
            state_d = IDLE;
        end else begin
          travel_d = travel_q + 8'd1;
        end
      end

      DOOR: begin
        if (call_here) begin
          door_d = DOOR_LOAD;
        end else if (door_q <= 8'd1) begin
          state_d = IDLE;
          door_d  = '0;
        end else begin
          door_d = door_q - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == DOOR && state_q != DOOR)
      door_d = DOOR_LOAD;
    if (state_d == UP && state_q != UP) begin
      last_dir_d = 1'b1;
      travel_d   = '0;
    end
    if (state_d == DOWN && state_q != DOWN) begin
      last_dir_d = 1'b0;
      travel_d   = '0;
    end
  end

  // A call for the floor the door is open at is absorbed by the door hold.
  always_comb begin
    set_up = '0;
    set_dn = '0;
    clr    = '0;
    if (!(state_q == DOOR && bus.req_floor == floor_q)) begin
      if (call_up) set_up = 4'b0001 << bus.req_floor;
      if (call_dn) set_dn = 4'b0001 << bus.req_floor;
    end
    if (state_d == DOOR && state_q != DOOR)
      clr = 4'b0001 << floor_d;
    pend_up_d = (pend_up_q | set_up) & ~clr;
    pend_dn_d = (pend_dn_q | set_dn) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      floor_q    <= '0;
      last_dir_q <= 1'b1;
      pend_up_q  <= '0;
      pend_dn_q  <= '0;
      travel_q   <= '0;
      door_q     <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      last_dir_q <= last_dir_d;
      pend_up_q  <= pend_up_d;
      pend_dn_q  <= pend_dn_d;
      travel_q   <= travel_d;
      door_q     <= door_d;
    end
  end

  assign bus.floor      = floor_q;
  assign bus.motion     = (state_q == UP) ? 2'b11 : (state_q == DOWN) ? 2'b10 : 2'b00;
  assign bus.door_open  = (state_q == DOOR);
  assign bus.pending_up = pend_up_q;
  assign bus.pending_dn = pend_dn_q;
  assign bus.busy       = (state_q != IDLE) || (|pend_up_q) || (|pend_dn_q);

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8, clock cycles to move one floor; legal range 2..255.
REQ-002 Parameter DOOR_CYCLES, default 4, clock cycles the door stays open; legal range 2..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  hall/cab call strobe, sampled each cycle.
REQ-006 req_floor  input  2  requested floor 0..3.
REQ-007 req_dir  input  2  call code: 11 = up call, 10 = down call, 00 = no call, 01 = invalid.
REQ-008 floor  output  2  current car floor.
REQ-009 motion  output  2  11 = moving up, 10 = moving down, 00 = stopped (same encoding as req_dir).
REQ-010 door_open  output  1  high while the car is in DOOR state.
REQ-011 pending_up  output  4  latched up calls, bit n = floor n.
REQ-012 pending_dn  output  4  latched down calls, bit n = floor n.
REQ-013 busy  output  1  high whenever state is not IDLE or any pending bit is set.

Function
REQ-014 States SHALL be IDLE, UP, DOWN, DOOR; encoded in a registered state variable plus a 1-bit last_dir (1 = up).
REQ-015 When req_valid=1 and req_dir=11 with req_floor<3, pending_up[req_floor] SHALL set on the next edge; up call at floor 3 ignored.
REQ-016 When req_valid=1 and req_dir=10 with req_floor>0, pending_dn[req_floor] SHALL set on the next edge; down call at floor 0 ignored.
REQ-017 req_dir 00 or 01 SHALL be ignored regardless of req_valid.
REQ-018 IDLE: if either pending bit at floor is set, or a valid call for floor arrives this cycle, next state SHALL be DOOR.
REQ-019 IDLE otherwise: calls above and below -> continue last_dir; only above -> UP; only below -> DOWN; none -> stay IDLE.
REQ-020 UP/DOWN: a travel counter SHALL count TRAVEL_CYCLES cycles, then floor increments/decrements by exactly 1 on that edge and counter reloads.
REQ-021 On arrival in UP: next state DOOR if pending_up[floor] set or no call exists above floor; else remain UP. DOWN symmetric with pending_dn and below.
REQ-022 floor SHALL never exceed 3 nor go below 0; UP at floor 3 or DOWN at floor 0 SHALL go to DOOR if calls at floor, else IDLE.
REQ-023 On entry to DOOR, both pending_up[floor] and pending_dn[floor] SHALL clear; door counter loads DOOR_CYCLES.
REQ-024 In DOOR, a valid call for the current floor SHALL not set a pending bit and SHALL reload the door counter (door held).
REQ-025 Same-cycle set and clear of the same pending bit: clear wins.
REQ-026 DOOR exits to IDLE after DOOR_CYCLES cycles; last_dir updates only on entry to UP or DOWN.
REQ-027 motion SHALL be 11 in UP, 10 in DOWN, 00 in IDLE and DOOR; door_open=1 only in DOOR (never while moving).
REQ-028 Latency: call accepted in IDLE at another floor -> motion nonzero 2 cycles after the req_valid edge (latch, then state).
REQ-029 Calls arriving during UP/DOWN SHALL be latched without disturbing the travel counter.

Reset
REQ-030 With rst=1 at an edge: state=IDLE, floor=0, motion=00, door_open=0, pending_up=pending_dn=0000, last_dir=1, counters=0, busy=0.
REQ-031 Reset mid-travel or mid-door SHALL take effect on that edge; calls presented with rst=1 are discarded.

Verification
REQ-032 After reset, req up at floor 2 -> motion=11 two cycles later, floor=1 after 8 cycles, floor=2 after 16, door_open high 4 cycles, pending_up=0000, then IDLE.
REQ-033 Car at 0 in IDLE, call floor 0 up -> door_open=1 next cycle, pending_up stays 0000.
REQ-034 Car moving up from 0 to 3, down call at floor 1 injected -> car passes floor 1, serves 3, then returns down to 1; pending_dn[1] clears on door entry.
REQ-035 Invalid calls (up at 3, down at 0, req_dir=01) -> pending vectors unchanged, busy stays 0.
REQ-036 Call for current floor during DOOR at cycle 3 of 4 -> door_open extends by full DOOR_CYCLES.
REQ-037 rst asserted while moving between floors 1 and 2 -> next cycle floor=0, motion=00, all pending cleared.
